axi_sram_responder: RTL and testbench
=====================================

Name: axi_sram_responder

Overview:
- AXI4 slave memory model that answers the GPGPU's external AXI master, i.e. the far end of the L2 cache's memory bus.
- Serves INCR read and write bursts from an internal word-addressed SRAM.
- Read and write channels run independently.
- Used as on-chip boot/data RAM in FPGA builds and as the memory endpoint in system simulation.

Parameters:
MEM_ADDR_WIDTH, 14, log2 of memory depth in 32-bit words (default 64 KiB).
READ_DELAY, 0, extra idle cycles between AR handshake and first R beat (0..15); models slow memory for core stall testing.

Ports:
clk  in  1  sole clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
s_awaddr  in  32  write burst byte address.
s_awlen  in  8  write beats minus 1.
s_awvalid  in  1  AW valid.
s_awready  out  1  AW ready.
s_wdata  in  32  write data.
s_wlast  in  1  last write beat (ignored; see Behaviour).
s_wvalid  in  1  W valid.
s_wready  out  1  W ready.
s_bvalid  out  1  write response valid.
s_bready  in  1  write response ready.
s_bresp  out  2  always 2'b00 OKAY.
s_araddr  in  32  read burst byte address.
s_arlen  in  8  read beats minus 1.
s_arvalid  in  1  AR valid.
s_arready  out  1  AR ready.
s_rdata  out  32  read data.
s_rlast  out  1  last read beat.
s_rvalid  out  1  read data valid.
s_rready  in  1  read data ready.
s_rresp  out  2  always 2'b00.

Behaviour:
- Interface fixed: one clock clk; reset_n is asynchronous and active-low.
- Reset: all outputs are registered and cleared to 0 while reset_n is low. s_awready and s_arready rise in the first cycle after release. SRAM contents are not reset.
- Addressing:
  - Word index is addr[MEM_ADDR_WIDTH+1:2]. Upper bits and addr[1:0] are ignored.
  - Burst address increments by one word per beat, modulo 2^MEM_ADDR_WIDTH (wrap-around, no error).
  - Burst type, size and wstrb are not supported; every beat is a full 32-bit word.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: s_awready=1. On s_awvalid, latch address and beat count = awlen+1, go to W_DATA.
  - W_DATA: s_wready=1. Each s_wvalid cycle writes one word and decrements the count. The final counted beat goes to W_RESP.
  - Beat count alone terminates the burst; s_wlast is not checked.
  - W_RESP: s_bvalid=1 from the cycle after the last beat is accepted. Hold until s_bready, then return to W_IDLE.
  - Throughput: one beat per cycle.
- Read FSM, states R_IDLE, R_WAIT, R_FETCH, R_DATA:
  - R_IDLE: s_arready=1. On handshake in cycle N, latch address and count. Go to R_WAIT if READ_DELAY>0, else R_FETCH.
  - R_WAIT: down-counter from READ_DELAY; go to R_FETCH at zero.
  - R_FETCH: issue the SRAM read; go to R_DATA.
  - First s_rvalid appears at cycle N+2+READ_DELAY.
  - R_DATA: s_rvalid=1. s_rdata and s_rlast hold stable while s_rready=0.
  - On s_rvalid&&s_rready with beats remaining, the next word is read the same cycle, giving back-to-back beats at one per cycle.
  - s_rlast=1 exactly on beat awlen+1 (arlen+1 for reads). Its acceptance returns to R_IDLE with s_rvalid=0 the next cycle.
- Concurrency: read and write bursts may overlap. A read of a word written in the same cycle returns the old data.
- Asserting reset_n low mid-burst aborts both FSMs immediately. The partially written burst leaves the beats already written in memory.
- s_awready=0 outside W_IDLE and s_arready=0 outside R_IDLE; only one outstanding burst per direction.

Decomposition:
- Shared package axi_defines: AXI_RESP_OKAY constant, burst length type (8-bit), and the FSM state enums for both channels.
- One sub-module, sram_1r1w, holds the array: parameter DEPTH/WIDTH, one write port, one synchronous read port, read-during-write returns old data.

Test Plan:
1. Write burst awaddr 0x100, awlen 3, data 0xA0..0xA3 -> s_bvalid one cycle after the 4th beat, bresp 0. Then read araddr 0x100, arlen 3 -> 0xA0..0xA3 with s_rvalid first at N+2 and s_rlast only on the 4th beat.
2. Read burst arlen 7 with s_rready toggling 1,0,0,1,... -> all 8 words delivered in order; s_rdata and s_rlast unchanged during stall cycles.
3. MEM_ADDR_WIDTH=10: write awaddr 0xFFC, awlen 1, data 0x11, 0x22 -> word 1023 = 0x11, word 0 = 0x22. Read address 0x1000 returns 0x22.
4. READ_DELAY=3, single read -> first s_rvalid at cycle N+5; s_arready low from N+1 until after the rlast handshake.
5. Word 5 preloaded 0xDEAD; write 0xBEEF to word 5 in the same cycle the read FSM fetches it -> read returns 0xDEAD, and a later read returns 0xBEEF.
6. Write burst awlen 7, reset_n pulsed low after beat 3 -> s_wready and s_bvalid drop asynchronously. s_awready and s_arready are 1 one cycle after release. Words 0..2 of the burst hold the new data; words 3..7 keep their old contents.

Source files
------------

// File: rtl/axi_defines.sv
// Shared AXI constants, burst length type and the channel FSM state encodings.
package axi_defines;

  localparam int unsigned AXI_ADDR_W  = 32;
  localparam int unsigned AXI_DATA_W  = 32;
  localparam int unsigned AXI_LEN_W   = 8;
  localparam int unsigned DELAY_CNT_W = 4;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef logic [AXI_LEN_W-1:0] axi_len_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_FETCH = 2'd2,
    R_DATA  = 2'd3
  } r_state_e;

endpackage

// File: rtl/axi_sram_responder_if.sv
// AXI4 subset (INCR bursts, full words) between the memory-side master and the SRAM responder.
interface axi_sram_responder_if;
  import axi_defines::*;

  logic [AXI_ADDR_W-1:0] s_awaddr;
  axi_len_t              s_awlen;
  logic                  s_awvalid;
  logic                  s_awready;
  logic [AXI_DATA_W-1:0] s_wdata;
  logic                  s_wlast;
  logic                  s_wvalid;
  logic                  s_wready;
  logic                  s_bvalid;
  logic                  s_bready;
  logic [1:0]            s_bresp;
  logic [AXI_ADDR_W-1:0] s_araddr;
  axi_len_t              s_arlen;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [AXI_DATA_W-1:0] s_rdata;
  logic                  s_rlast;
  logic                  s_rvalid;
  logic                  s_rready;
  logic [1:0]            s_rresp;

  modport slave (
    input  s_awaddr, s_awlen, s_awvalid, s_wdata, s_wlast, s_wvalid, s_bready,
    input  s_araddr, s_arlen, s_arvalid, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp,
    output s_arready, s_rdata, s_rlast, s_rvalid, s_rresp
  );

  modport master (
    output s_awaddr, s_awlen, s_awvalid, s_wdata, s_wlast, s_wvalid, s_bready,
    output s_araddr, s_arlen, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp,
    input  s_arready, s_rdata, s_rlast, s_rvalid, s_rresp
  );

endinterface

// File: rtl/sram_1r1w.sv
// Simple dual-port RAM: one write port, one registered read port, read-during-write returns old data.
module sram_1r1w #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read register samples the pre-edge array, so a same-cycle write is not seen; holds when re is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 slave memory endpoint: independent INCR read/write burst engines over a word-addressed SRAM.
module axi_sram_responder
  import axi_defines::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 14,
  parameter int unsigned READ_DELAY     = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  axi_sram_responder_if.slave  s
);

  localparam int unsigned DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam int unsigned CNT_W = AXI_LEN_W + 1;

  typedef logic [MEM_ADDR_WIDTH-1:0] word_addr_t;

  w_state_e          w_state_q, w_state_d;
  word_addr_t        w_addr_q, w_addr_d;
  logic [CNT_W-1:0]  w_cnt_q, w_cnt_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic              mem_we_c;

  r_state_e               r_state_q, r_state_d;
  word_addr_t             r_addr_q, r_addr_d;
  logic [CNT_W-1:0]       r_cnt_q, r_cnt_d;
  logic [DELAY_CNT_W-1:0] r_wait_q, r_wait_d;
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic                   rlast_q, rlast_d;
  logic                   mem_re_c;
  logic [AXI_DATA_W-1:0]  rdata;

  logic unused_bits;
  assign unused_bits = ^{s.s_wlast,
                         s.s_awaddr[AXI_ADDR_W-1:MEM_ADDR_WIDTH+2], s.s_awaddr[1:0],
                         s.s_araddr[AXI_ADDR_W-1:MEM_ADDR_WIDTH+2], s.s_araddr[1:0]};

  // Write channel: accept AW, count beats into the array (wlast not trusted), then hold B until taken.
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_cnt_d   = w_cnt_q;
    mem_we_c  = 1'b0;
    case (w_state_q)
      W_IDLE: if (awready_q && s.s_awvalid) begin
        w_addr_d  = s.s_awaddr[MEM_ADDR_WIDTH+1:2];
        w_cnt_d   = CNT_W'(s.s_awlen) + CNT_W'(1);
        w_state_d = W_DATA;
      end
      W_DATA: if (wready_q && s.s_wvalid) begin
        mem_we_c = 1'b1;
        w_addr_d = w_addr_q + word_addr_t'(1);
        w_cnt_d  = w_cnt_q - CNT_W'(1);
        if (w_cnt_q == CNT_W'(1)) w_state_d = W_RESP;
      end
      W_RESP: if (bvalid_q && s.s_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Read channel: optional wait, prime the read register, then refetch on every accepted non-last beat.
  always_comb begin
    r_state_d = r_state_q;
    r_addr_d  = r_addr_q;
    r_cnt_d   = r_cnt_q;
    r_wait_d  = r_wait_q;
    rlast_d   = rlast_q;
    mem_re_c  = 1'b0;
    case (r_state_q)
      R_IDLE: if (arready_q && s.s_arvalid) begin
        r_addr_d  = s.s_araddr[MEM_ADDR_WIDTH+1:2];
        r_cnt_d   = CNT_W'(s.s_arlen) + CNT_W'(1);
        r_wait_d  = DELAY_CNT_W'(READ_DELAY);
        r_state_d = (READ_DELAY > 0) ? R_WAIT : R_FETCH;
      end
      R_WAIT: begin
        r_wait_d = r_wait_q - DELAY_CNT_W'(1);
        if (r_wait_q == DELAY_CNT_W'(1)) r_state_d = R_FETCH;
      end
      R_FETCH: begin
        mem_re_c  = 1'b1;
        r_addr_d  = r_addr_q + word_addr_t'(1);
        r_cnt_d   = r_cnt_q - CNT_W'(1);
        rlast_d   = (r_cnt_q == CNT_W'(1));
        r_state_d = R_DATA;
      end
      R_DATA: if (rvalid_q && s.s_rready) begin
        if (rlast_q) begin
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          mem_re_c = 1'b1;
          r_addr_d = r_addr_q + word_addr_t'(1);
          r_cnt_d  = r_cnt_q - CNT_W'(1);
          rlast_d  = (r_cnt_q == CNT_W'(1));
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  // State and registered handshake outputs for both channels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_cnt_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_cnt_q   <= '0;
      r_wait_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_cnt_q   <= w_cnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_cnt_q   <= r_cnt_d;
      r_wait_q  <= r_wait_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  sram_1r1w #(
    .DEPTH (DEPTH),
    .WIDTH (AXI_DATA_W)
  ) u_sram (
    .clk   (clk),
    .rst_n (reset_n),
    .we    (mem_we_c),
    .waddr (w_addr_q),
    .wdata (s.s_wdata),
    .re    (mem_re_c),
    .raddr (r_addr_q),
    .rdata (rdata)
  );

  assign s.s_awready = awready_q;
  assign s.s_wready  = wready_q;
  assign s.s_bvalid  = bvalid_q;
  assign s.s_bresp   = AXI_RESP_OKAY;
  assign s.s_arready = arready_q;
  assign s.s_rvalid  = rvalid_q;
  assign s.s_rlast   = rlast_q;
  assign s.s_rdata   = rdata;
  assign s.s_rresp   = AXI_RESP_OKAY;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Randomised bench for axi_sram_responder with a word-array reference model and R/B scoreboards.
module tb_axi_sram_responder;
  import axi_defines::*;

  localparam int unsigned MAW   = 10;
  localparam int unsigned RD    = 3;
  localparam int unsigned DEPTH = 1 << MAW;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  axi_sram_responder_if bus();

  axi_sram_responder #(
    .MEM_ADDR_WIDTH (MAW),
    .READ_DELAY     (RD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s       (bus)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem_model [DEPTH];
  logic [31:0] wbuf [256];
  logic [32:0] r_exp [$];   // {last, data}
  logic [1:0]  b_exp [$];
  bit rr_pattern = 1'b0;
  int rr_phase = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word index of beat 'beat' of a burst starting at byte address 'addr', wrapping at the memory size.
  function automatic int unsigned widx(input logic [31:0] addr, input int unsigned beat);
    int unsigned w;
    w = 32'(addr >> 2) + beat;
    return w % DEPTH;
  endfunction

  // Ready drivers: random, or a 1,0,0 repeating rready pattern.
  initial begin
    bus.s_rready = 1'b0;
    bus.s_bready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rr_pattern) begin
        bus.s_rready = (rr_phase % 3 == 0);
        rr_phase++;
      end else begin
        bus.s_rready = ($urandom_range(0, 3) != 0);
      end
      bus.s_bready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops the scoreboards on R/B handshakes and checks R stability across stalls.
  initial begin
    logic [31:0] hold_data;
    logic        hold_last;
    bit          holding;
    logic [32:0] e;
    logic [1:0]  eb;
    holding = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        holding = 1'b0;
      end else begin
        if (bus.s_rvalid) begin
          if (holding) begin
            check("rdata_stable_in_stall", bus.s_rdata, hold_data);
            check("rlast_stable_in_stall", bus.s_rlast, hold_last);
          end
          check("arready_low_during_r", bus.s_arready, 0);
          if (bus.s_rready) begin
            if (r_exp.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL r_unexpected_beat: got data 0x%0h with no beat expected at %0t", bus.s_rdata, $time);
            end else begin
              e = r_exp.pop_front();
              check("rdata", bus.s_rdata, e[31:0]);
              check("rlast", bus.s_rlast, e[32]);
              check("rresp", bus.s_rresp, AXI_RESP_OKAY);
            end
            holding = 1'b0;
          end else begin
            holding   = 1'b1;
            hold_data = bus.s_rdata;
            hold_last = bus.s_rlast;
          end
        end else begin
          holding = 1'b0;
        end
        if (bus.s_bvalid && bus.s_bready) begin
          if (b_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected: got bresp 0x%0h with no response expected at %0t", bus.s_bresp, $time);
          end else begin
            eb = b_exp.pop_front();
            check("bresp", bus.s_bresp, eb);
          end
        end
      end
    end
  end

  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("awready_after_reset", bus.s_awready, 1);
    check("arready_after_reset", bus.s_arready, 1);
  endtask

  task automatic write_burst(input logic [31:0] addr, input int len, input int abort_after);
    int g;
    bus.s_awaddr  = addr;
    bus.s_awlen   = 8'(len);
    bus.s_awvalid = 1'b1;
    g = 0;
    while (!bus.s_awready && g < 200) begin @(posedge clk); #1; g++; end
    check("aw_handshake_timeout", 64'(g >= 200), 0);
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      bus.s_wdata  = wbuf[i];
      bus.s_wlast  = (i == len) ^ ($urandom_range(0, 7) == 0);
      bus.s_wvalid = 1'b1;
      g = 0;
      while (!bus.s_wready && g < 200) begin @(posedge clk); #1; g++; end
      check("w_handshake_timeout", 64'(g >= 200), 0);
      @(posedge clk); #1;
      bus.s_wvalid = 1'b0;
      bus.s_wlast  = 1'b0;
      mem_model[widx(addr, i)] = wbuf[i];
      if (abort_after == i + 1) begin
        #1 reset_n = 1'b0;
        #1;
        check("wready_async_drop", bus.s_wready, 0);
        check("bvalid_in_reset", bus.s_bvalid, 0);
        check("awready_in_reset", bus.s_awready, 0);
        check("arready_in_reset", bus.s_arready, 0);
        release_reset();
        return;
      end
    end
    check("bvalid_after_last_beat", bus.s_bvalid, 1);
    check("wready_after_last_beat", bus.s_wready, 0);
    b_exp.push_back(AXI_RESP_OKAY);
    g = 0;
    while (bus.s_bvalid && g < 200) begin @(posedge clk); #1; g++; end
    check("b_handshake_timeout", 64'(g >= 200), 0);
  endtask

  task automatic read_burst(input logic [31:0] addr, input int len);
    int g;
    for (int i = 0; i <= len; i++) r_exp.push_back({(i == len), mem_model[widx(addr, i)]});
    bus.s_araddr  = addr;
    bus.s_arlen   = 8'(len);
    bus.s_arvalid = 1'b1;
    g = 0;
    while (!bus.s_arready && g < 200) begin @(posedge clk); #1; g++; end
    check("ar_handshake_timeout", 64'(g >= 200), 0);
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
    check("arready_after_ar", bus.s_arready, 0);
    g = 0;
    while (!bus.s_rvalid && g < 64) begin
      @(posedge clk); #1;
      check("arready_low_before_r", bus.s_arready, 0);
      g++;
    end
    check("first_rvalid_latency", 64'(g), 64'(RD + 1));
    g = 0;
    while (r_exp.size() != 0 && g < 2000) begin @(posedge clk); g++; end
    check("r_drain_timeout", 64'(g >= 2000), 0);
    #1;
    check("arready_after_rlast", bus.s_arready, 1);
    check("rvalid_after_rlast", bus.s_rvalid, 0);
  endtask

  initial begin
    int g;
    bus.s_awaddr  = '0;
    bus.s_awlen   = '0;
    bus.s_awvalid = 1'b0;
    bus.s_wdata   = '0;
    bus.s_wlast   = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_araddr  = '0;
    bus.s_arlen   = '0;
    bus.s_arvalid = 1'b0;

    // Reset values
    #2 reset_n = 1'b0;
    #1;
    check("rst_awready", bus.s_awready, 0);
    check("rst_arready", bus.s_arready, 0);
    check("rst_wready",  bus.s_wready, 0);
    check("rst_bvalid",  bus.s_bvalid, 0);
    check("rst_rvalid",  bus.s_rvalid, 0);
    check("rst_rlast",   bus.s_rlast, 0);
    check("rst_rdata",   bus.s_rdata, 0);
    release_reset();

    // Fill the whole array so every later read has a known expectation
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
      write_burst(32'(b * 1024), 255, 0);
    end

    // Basic 4-beat write/read at 0x100
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
    write_burst(32'h100, 3, 0);
    read_burst(32'h100, 3);

    // 8-beat read with rready 1,0,0 stalls
    rr_pattern = 1'b1;
    read_burst(32'h200, 7);
    rr_pattern = 1'b0;

    // Wrap at the top of a 1024-word array
    wbuf[0] = 32'h11;
    wbuf[1] = 32'h22;
    write_burst(32'hFFC, 1, 0);
    read_burst(32'hFFC, 1);
    read_burst(32'h1000, 0);

    // Write lands on word 5 in the same cycle the read engine fetches it
    wbuf[0] = 32'hDEAD;
    write_burst(32'h14, 0, 0);
    bus.s_awaddr  = 32'h14;
    bus.s_awlen   = 8'd0;
    bus.s_awvalid = 1'b1;
    g = 0;
    while (!bus.s_awready && g < 200) begin @(posedge clk); #1; g++; end
    check("collide_aw_timeout", 64'(g >= 200), 0);
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0;
    r_exp.push_back({1'b1, mem_model[5]});
    bus.s_araddr  = 32'h14;
    bus.s_arlen   = 8'd0;
    bus.s_arvalid = 1'b1;
    g = 0;
    while (!bus.s_arready && g < 200) begin @(posedge clk); #1; g++; end
    check("collide_ar_timeout", 64'(g >= 200), 0);
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
    repeat (RD) @(posedge clk);
    #1;
    bus.s_wdata  = 32'hBEEF;
    bus.s_wlast  = 1'b1;
    bus.s_wvalid = 1'b1;
    @(posedge clk); #1;
    bus.s_wvalid = 1'b0;
    bus.s_wlast  = 1'b0;
    mem_model[5] = 32'hBEEF;
    check("collide_rvalid_aligned", bus.s_rvalid, 1);
    check("collide_bvalid", bus.s_bvalid, 1);
    b_exp.push_back(AXI_RESP_OKAY);
    g = 0;
    while ((bus.s_bvalid || r_exp.size() != 0) && g < 200) begin @(posedge clk); #1; g++; end
    check("collide_drain_timeout", 64'(g >= 200), 0);
    @(posedge clk); #1;
    read_burst(32'h14, 0);

    // Reset in the middle of an 8-beat write after 3 accepted beats
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hC0DE_0000 + 32'(i);
    write_burst(32'h40, 7, 3);
    read_burst(32'h40, 7);

    // Random bursts anywhere in the 32-bit address space
    repeat (12) begin
      int len;
      logic [31:0] a;
      a   = $urandom;
      len = $urandom_range(0, 15);
      for (int i = 0; i <= len; i++) wbuf[i] = $urandom;
      write_burst(a, len, 0);
      if ($urandom_range(0, 1) == 0) read_burst(a, len);
      else read_burst($urandom, $urandom_range(0, 31));
    end

    repeat (4) @(posedge clk);
    #1;
    check("r_scoreboard_empty", 64'(r_exp.size()), 0);
    check("b_scoreboard_empty", 64'(b_exp.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
